// File: rtl/quad_counter_pkg.sv
// Shared constants and helpers for the quadrature counter array:
// decode-mode encodings, the four {A,B} phase codes and the forward
// phase successor used by the per-channel decoder.
package quad_counter_pkg;

  // One quadrature phase sample, bit 1 = A, bit 0 = B
  typedef logic [1:0] phase_t;

  // Decode resolution selectors; 2'b11 falls through to full x4 decoding
  localparam logic [1:0] MODE_X1 = 2'b00;
  localparam logic [1:0] MODE_X2 = 2'b01;
  localparam logic [1:0] MODE_X4 = 2'b10;

  // Phase codes in forward order: 00 -> 10 -> 11 -> 01 -> 00
  localparam phase_t PHASE_00 = 2'b00;
  localparam phase_t PHASE_10 = 2'b10;
  localparam phase_t PHASE_11 = 2'b11;
  localparam phase_t PHASE_01 = 2'b01;

  // Phase that follows p when the encoder turns forward.
  // A reverse step is simply the case where next_phase(new) == old.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PHASE_00: next_phase = PHASE_10;
      PHASE_10: next_phase = PHASE_11;
      PHASE_11: next_phase = PHASE_01;
      default:  next_phase = PHASE_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_counter_array_if.sv
// Bundle of the per-channel encoder inputs, the shared mode controls and
// the packed per-channel results of the quadrature counter array.
// master = the side that drives encoder pins and controls,
// slave  = the counter array itself.
interface quad_counter_array_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
);

  logic [CHANNELS-1:0]       quad_a;
  logic [CHANNELS-1:0]       quad_b;
  logic [1:0]                mode;
  logic                      wrap_en;
  logic [CHANNELS-1:0]       clear;
  logic [CHANNELS-1:0]       err_clr;
  logic [CHANNELS*WIDTH-1:0] count;
  logic [CHANNELS-1:0]       dir;
  logic [CHANNELS-1:0]       step;
  logic [CHANNELS-1:0]       err;

  modport master (
    output quad_a,
    output quad_b,
    output mode,
    output wrap_en,
    output clear,
    output err_clr,
    input  count,
    input  dir,
    input  step,
    input  err
  );

  modport slave (
    input  quad_a,
    input  quad_b,
    input  mode,
    input  wrap_en,
    input  clear,
    input  err_clr,
    output count,
    output dir,
    output step,
    output err
  );

endinterface

// File: rtl/quad_channel.sv
// One quadrature channel: 2-flop synchroniser, run-length glitch filter,
// transition decoder and the up/down counter with wrap/saturate, clear
// and sticky illegal-transition flag.
module quad_channel
  import quad_counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FILTER_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic [1:0]       mode,
  input  logic             wrap_en,
  input  logic             clear,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  // FILTER_LEN is at most 15, so four bits always hold the run length
  localparam int RUN_W = 4;
  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(FILTER_LEN - 1);
  localparam logic [WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [WIDTH-1:0] COUNT_MIN = '0;

  phase_t           sync1;
  phase_t           sync2;
  phase_t           filt;
  phase_t           filt_prev;
  logic [RUN_W-1:0] run;

  logic             is_fwd;
  logic             is_rev;
  logic             is_illegal;
  logic             a_moved;
  logic             fire;
  logic [WIDTH-1:0] count_next;

  // Bring both asynchronous encoder pins into the clock domain together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= PHASE_00;
      sync2 <= PHASE_00;
    end else begin
      sync1 <= {quad_a, quad_b};
      sync2 <= sync1;
    end
  end

  // Accept a new phase only once it has differed for FILTER_LEN straight cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= PHASE_00;
      run  <= '0;
    end else if (sync2 == filt) begin
      run <= '0;
    end else if (run == RUN_LAST) begin
      filt <= sync2;
      run  <= '0;
    end else begin
      run <= run + 1'b1;
    end
  end

  // Keep the previously accepted phase so each accepted change is seen once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_prev <= PHASE_00;
    end else begin
      filt_prev <= filt;
    end
  end

  // Classify the accepted transition and decide whether it counts in this mode
  always_comb begin
    is_fwd     = (next_phase(filt_prev) == filt);
    is_rev     = (next_phase(filt) == filt_prev);
    is_illegal = ((filt_prev ^ filt) == 2'b11);
    a_moved    = filt_prev[1] ^ filt[1];
    fire       = 1'b0;
    case (mode)
      MODE_X1: fire = ((filt_prev == PHASE_00) && (filt == PHASE_10)) ||
                      ((filt_prev == PHASE_10) && (filt == PHASE_00));
      MODE_X2: fire = (is_fwd || is_rev) && a_moved;
      MODE_X4: fire = is_fwd || is_rev;
      default: fire = is_fwd || is_rev;
    endcase
  end

  // Next count value for a step, wrapping or saturating at either end
  always_comb begin
    count_next = count;
    if (is_fwd) begin
      if (count == COUNT_MAX) begin
        count_next = wrap_en ? COUNT_MIN : COUNT_MAX;
      end else begin
        count_next = count + 1'b1;
      end
    end else begin
      if (count == COUNT_MIN) begin
        count_next = wrap_en ? COUNT_MAX : COUNT_MIN;
      end else begin
        count_next = count - 1'b1;
      end
    end
  end

  // Register count, direction, step pulse and sticky error; clear beats a step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      dir   <= 1'b1;
      step  <= 1'b0;
      err   <= 1'b0;
    end else begin
      step <= fire;
      if (fire) begin
        dir <= is_fwd;
      end
      if (clear) begin
        count <= '0;
      end else if (fire) begin
        count <= count_next;
      end
      if (is_illegal) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/quad_counter_array.sv
// Array of independent quadrature channel counters sharing one clock,
// one decode mode and one wrap/saturate selection. Per-channel results
// are packed onto the bus with channel i at count[i*WIDTH +: WIDTH].
module quad_counter_array #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 8,
  parameter int FILTER_LEN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  quad_counter_array_if.slave  bus
);

  logic [WIDTH-1:0]    count_ch [CHANNELS];
  logic [CHANNELS-1:0] dir_ch;
  logic [CHANNELS-1:0] step_ch;
  logic [CHANNELS-1:0] err_ch;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    quad_channel #(
      .WIDTH      (WIDTH),
      .FILTER_LEN (FILTER_LEN)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .quad_a  (bus.quad_a[i]),
      .quad_b  (bus.quad_b[i]),
      .mode    (bus.mode),
      .wrap_en (bus.wrap_en),
      .clear   (bus.clear[i]),
      .err_clr (bus.err_clr[i]),
      .count   (count_ch[i]),
      .dir     (dir_ch[i]),
      .step    (step_ch[i]),
      .err     (err_ch[i])
    );
  end

  // Pack the per-channel counts into the flat output vector
  always_comb begin
    bus.count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.count[i*WIDTH +: WIDTH] = count_ch[i];
    end
  end

  assign bus.dir  = dir_ch;
  assign bus.step = step_ch;
  assign bus.err  = err_ch;

endmodule

// File: doc/quad_counter_array.md
QUAD_COUNTER_ARRAY -- requirements
Module: quad_counter_array

Interface
REQ-001 Parameter CHANNELS, default 2, number of independent quadrature channels (1..8).
REQ-002 Parameter WIDTH, default 8, counter width per channel in bits (2..16).
REQ-003 Parameter FILTER_LEN, default 3, consecutive stable cycles required to accept an input change (1..15).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 quad_a  input  CHANNELS  channel A phase per channel, asynchronous to clk.
REQ-007 quad_b  input  CHANNELS  channel B phase per channel, asynchronous to clk.
REQ-008 mode  input  2  decode resolution: 00 x1, 01 x2, 10 x4, 11 treated as x4.
REQ-009 wrap_en  input  1  1 = modular counting, 0 = saturating counting.
REQ-010 clear  input  CHANNELS  synchronous per-channel counter clear.
REQ-011 err_clr  input  CHANNELS  synchronous per-channel error flag clear.
REQ-012 count  output  CHANNELS*WIDTH  channel i count in bits [i*WIDTH +: WIDTH].
REQ-013 dir  output  CHANNELS  last accepted direction per channel, 1 = forward.
REQ-014 step  output  CHANNELS  one-cycle pulse on every count change attempt (including saturated attempts).
REQ-015 err  output  CHANNELS  sticky illegal-transition flag.

Function
REQ-016 Each quad_a/quad_b bit SHALL pass through a 2-flop synchroniser before any other logic.
REQ-017 Filtered phase {A,B} SHALL update only after the synchronised value has differed from it for FILTER_LEN consecutive cycles; any intermediate return to the filtered value SHALL restart the run.
REQ-018 A pin change stable from before edge 0 SHALL update count/dir/step on edge FILTER_LEN+2 (latency FILTER_LEN+2 cycles).
REQ-019 Forward sequence of {A,B}: 00->10->11->01->00; reverse is the inverse order.
REQ-020 x4: every legal filtered transition SHALL produce one step in its direction.
REQ-021 x2: only legal transitions in which A changes SHALL produce a step.
REQ-022 x1: only 00->10 (forward) and 10->00 (reverse) SHALL produce a step.
REQ-023 Illegal transition (A and B change together): no step, count and dir unchanged, err set.
REQ-024 wrap_en=1: forward from 2^WIDTH-1 gives 0; reverse from 0 gives 2^WIDTH-1.
REQ-025 wrap_en=0: count SHALL hold at 2^WIDTH-1 going forward and at 0 going reverse; step still pulses, dir still updates.
REQ-026 clear SHALL load count 0 on the next edge and take priority over a simultaneous step; dir and err unaffected.
REQ-027 err set by an event in the same cycle as err_clr SHALL win (err stays 1).
REQ-028 mode and wrap_en changes SHALL apply from the next edge; no retroactive recount of past transitions.
REQ-029 Channels SHALL be fully independent; no shared state except parameters and mode/wrap_en.

Reset
REQ-030 rst SHALL asynchronously force: count 0, dir 1, step 0, err 0, filter run counters 0.
REQ-031 Synchroniser and filtered phase registers SHALL reset to 00; first post-reset transition from 00 is decoded normally.
REQ-032 Reset asserted mid-transition SHALL discard any partial filter run; no step on reset release.

Structure
REQ-033 Package quad_counter_pkg SHALL hold the mode encoding constants (MODE_X1, MODE_X2, MODE_X4) and the four phase constants.
REQ-034 Per-channel logic SHALL be a sub-module quad_channel (sync, filter, decode, counter), instantiated CHANNELS times by a generate loop.

Verification (CHANNELS=2, WIDTH=8, FILTER_LEN=3)
REQ-035 Ch0 x4, 4 forward phases (one full cycle), 10 cycles per phase -> count0 = 4, dir0 = 1, four step0 pulses, each 5 cycles after its pin change; count1 = 0.
REQ-036 Same cycle under x2 then x1 -> count0 = 2 then 1; reverse cycle in x1 from 1 -> count0 = 0, dir0 = 0.
REQ-037 wrap_en=0, x4, one reverse phase from 0 -> count0 stays 0, step0 pulses; wrap_en=1 repeat -> count0 = 255.
REQ-038 2-cycle glitch on quad_a[0] -> no change in count0, dir0, step0.
REQ-039 A and B toggled together on ch1 -> err1 = 1, count1 unchanged; err_clr[1] pulse -> err1 = 0; clear[0] coinciding with a step -> count0 = 0.
REQ-040 rst asserted during a filter run, released -> all outputs at reset values, no step after release.
